// File: rtl/hydra_sram_pkg.sv
// Shared types and sizes for the packet SRAM read path.
// State codes are plain constants so older tools and netlists can consume them.
package hydra_sram_pkg;

  localparam int SRAM_ADDR_WIDTH = 14;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int SRAM_DEPTH      = 16384;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t IDLE  = 2'd0;
  localparam rd_state_t READ  = 2'd1;
  localparam rd_state_t DRAIN = 2'd2;

  typedef struct packed {
    logic [SRAM_DATA_WIDTH-1:0] data;
    logic                       last;
  } rd_beat_t;

endpackage

// File: rtl/sram_read_streamer_if.sv
// Request, SRAM read port and output stream of the read streamer.
// The streamer uses "slave"; the requester/SRAM/sink side uses "master".
interface sram_read_streamer_if
  import hydra_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport slave (
    input  req_valid, req_addr, req_len, rd_data, out_ready,
    output req_ready, rd_en, rd_addr, out_valid, out_data, out_last, busy, done
  );

  modport master (
    output req_valid, req_addr, req_len, rd_data, out_ready,
    input  req_ready, rd_en, rd_addr, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/sram_rd_skid_fifo.sv
// Two-entry shifting register FIFO; entry0 is always the head.
// Callers never push when full or pop when empty.
module sram_rd_skid_fifo
  import hydra_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rd_beat_t   push_beat,
  input  logic       pop,
  output logic [1:0] count,
  output rd_beat_t   head
);

  rd_beat_t entry0;
  rd_beat_t entry1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_beat;
          else               entry1 <= push_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands behind the survivor.
          if (count == 2'd1) begin
            entry0 <= push_beat;
          end else begin
            entry0 <= entry1;
            entry1 <= push_beat;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  assign head = entry0;

endmodule

// File: rtl/sram_read_streamer.sv
// Burst reader for the packet SRAM: issues sequential reads and streams the
// 1-cycle-latency read data out through a 2-entry skid FIFO with last marking.
module sram_read_streamer
  import hydra_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int DATA_DEPTH = SRAM_DEPTH,
  parameter int LEN_WIDTH  = 8
)
(
  input logic clk,
  input logic rst,
  sram_read_streamer_if.slave bus
);

  rd_state_t             state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  rd_pending;
  logic                  pending_last;
  logic                  zero_done;
  logic [1:0]            fifo_count;
  rd_beat_t              head;
  rd_beat_t              push_beat;
  logic                  pop;
  logic                  issue;
  logic                  last_pop;
  logic [2:0]            credit;

  // Credit counts words buffered or in flight after this cycle's pop.
  always_comb begin
    pop       = (fifo_count != 2'd0) && bus.out_ready;
    credit    = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
    issue     = (state == READ) && (credit < 3'd2) && !rst;
    last_pop  = (state == DRAIN) && pop && head.last;
    addr_next = (addr == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      rd_pending   <= 1'b0;
      pending_last <= 1'b0;
      zero_done    <= 1'b0;
    end else begin
      rd_pending   <= issue;
      pending_last <= issue && (remaining == LEN_WIDTH'(1));
      zero_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_len == '0) begin
              zero_done <= 1'b1;
            end else begin
              addr      <= bus.req_addr;
              remaining <= bus.req_len;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr      <= addr_next;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign push_beat = {SRAM_DATA_WIDTH'(bus.rd_data), pending_last};

  sram_rd_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending),
    .push_beat (push_beat),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.rd_en     = issue;
  assign bus.rd_addr   = addr;
  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_data  = DATA_WIDTH'(head.data);
  assign bus.out_last  = head.last;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (zero_done || last_pop) && !rst;

endmodule
